fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, 32'h80000000, first fetch PC after reset; SHALL be 4-byte aligned.
REQ-002 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 io_icache_req_valid  out  1  fetch request valid; io_icache_req_ready  in  1  cache accepts request.
REQ-005 io_icache_req_addr  out  32  request address, always PC with bits [2:0] cleared.
REQ-006 io_icache_resp_valid  in  1; io_icache_resp_data  in  64; io_icache_resp_excp  in  1; io_icache_resp_cause  in  6: one response per accepted request.
REQ-007 io_out_valid  out  1  packet valid toward Predecode; io_out_ready  in  1  Predecode accepts.
REQ-008 io_Address  out  32; io_data  out  64; io_excp_vaild  out  1; io_excp_cause  out  6; io_excpt_tval  out  32: packet fields.
REQ-009 io_fetch_id  out  4  packet sequence tag.
REQ-010 io_fetch_flush  in  1; io_Redirect_ID  in  4; io_Redirect_Target  in  32: redirect from Predecode.

Function
REQ-011 States SHALL be REQ, WAIT, HOLD, DRAIN, STOP; at most one request outstanding.
REQ-012 REQ: io_icache_req_valid=1; on req_valid&req_ready, packet PC latched, PC <= {PC[31:3],3'b0}+8 (mod 2^32, wrap permitted), go WAIT.
REQ-013 WAIT: on resp_valid, load packet registers (Address=packet PC, data, excp, cause, tval=packet PC when excp else 0), io_out_valid<=1, go HOLD.
REQ-014 HOLD: on io_out_valid&io_out_ready, io_fetch_id<=io_fetch_id+1 (mod 16), io_out_valid<=0; go STOP if delivered packet had excp, else REQ.
REQ-015 Packet outputs SHALL be registered and stable while io_out_valid=1 and io_out_ready=0.
REQ-016 STOP: no requests; leave only on io_fetch_flush.
REQ-017 io_fetch_flush SHALL take priority over every other event in every state: PC<=io_Redirect_Target, io_fetch_id<=io_Redirect_ID+1, io_out_valid<=0 at the same edge.
REQ-018 Flush next state: DRAIN if a request is outstanding after this edge (WAIT without resp_valid, or REQ with req handshake in the same cycle); else REQ.
REQ-019 DRAIN: discard the next response, go REQ; a further flush in DRAIN only updates PC/ID.
REQ-020 Redirect target with bits [1:0]!=0: no cache request; after any drain, SHALL deliver one packet with io_excp_vaild=1, io_excp_cause=6'h0, io_excpt_tval=target, io_Address=target, io_data=0, then go STOP.
REQ-021 Response in HOLD, REQ or STOP is a protocol violation; it SHALL be ignored.
REQ-022 Minimum latency: request accept to io_out_valid = 1 cycle after resp_valid edge; back-to-back throughput one packet per 3 cycles with zero-wait cache.

Reset
REQ-023 On reset: state REQ, PC=RESET_VECTOR, io_fetch_id=0, io_out_valid=0, all packet outputs 0; io_icache_req_valid=1 in the first cycle after reset.
REQ-024 Reset mid-operation SHALL abandon any outstanding request; the cache is reset on the same signal and produces no stale response.

Configuration
REQ-025 Macro FETCH_UNIT_PERF_CNT_EN defined: add outputs io_perf_pkts (out 32, delivered packets) and io_perf_flushes (out 32, flush cycles), both zero on reset, wrapping at 2^32.
REQ-026 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset, cache ready, 1-cycle responses, out_ready=1 -> requests 0x80000000, 0x80000008, 0x80000010; io_fetch_id 0,1,2.
REQ-028 out_ready=0 for 5 cycles in HOLD -> io_out_valid and packet fields constant, no new request; accept then next req addr=old PC+8.
REQ-029 Flush target 0x1004, ID 7 while WAIT -> late response dropped, next request 0x1000, packet Address 0x1004, io_fetch_id 8.
REQ-030 Flush target 0x2002 -> no request, packet excp_vaild=1, cause 0, tval 0x2002, then STOP until next flush.
REQ-031 Response excp=1 cause 6'h1 at PC 0x3000 -> packet tval 0x3000, no requests until flush; PC 0xFFFFFFF8 fetch -> next request 0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues 8-byte-aligned I-cache requests, one at a time,
// and hands each response to Predecode as a registered packet.
// It handles Predecode redirects, which may arrive on any cycle.
// A redirect to a target that is not 4-byte aligned produces an exception packet
// instead of a cache request.
// Optional build macro FETCH_UNIT_PERF_CNT_EN adds two performance counters:
// io_perf_pkts and io_perf_flushes.
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        io_icache_req_valid,
   input  logic        io_icache_req_ready,
   output logic [31:0] io_icache_req_addr,
   input  logic        io_icache_resp_valid,
   input  logic [63:0] io_icache_resp_data,
   input  logic        io_icache_resp_excp,
   input  logic [5:0]  io_icache_resp_cause,
   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic [31:0] io_Address,
   output logic [63:0] io_data,
   output logic        io_excp_vaild,
   output logic [5:0]  io_excp_cause,
   output logic [31:0] io_excpt_tval,
   output logic [3:0]  io_fetch_id,
`ifdef FETCH_UNIT_PERF_CNT_EN
   output logic [31:0] io_perf_pkts,
   output logic [31:0] io_perf_flushes,
`endif
   input  logic        io_fetch_flush,
   input  logic [3:0]  io_Redirect_ID,
   input  logic [31:0] io_Redirect_Target
);

   typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_STOP} state_t;

   state_t      state_q;
   logic [31:0] pc_q, pkt_pc_q;
   logic        misal_q;      // pending misaligned-redirect exception packet
   logic        out_valid_q, excp_q;
   logic [31:0] addr_q, tval_q;
   logic [63:0] data_q;
   logic [5:0]  cause_q;
   logic [3:0]  id_q;

   logic [31:0] pc_inc_d;
   logic        req_fire, out_fire, outstanding_d;

   assign io_icache_req_valid = (state_q == S_REQ) && !misal_q;
   assign io_icache_req_addr  = {pc_q[31:3], 3'b000};
   assign req_fire            = io_icache_req_valid && io_icache_req_ready;
   assign out_fire            = out_valid_q && io_out_ready;
   assign pc_inc_d            = {pc_q[31:3], 3'b000} + 32'd8;
   // A request is still in flight after this edge if the cache is being
   // handed one now, or one is pending and its response is not arriving now.
   assign outstanding_d = (state_q == S_REQ && req_fire) ||
                          ((state_q == S_WAIT || state_q == S_DRAIN) && !io_icache_resp_valid);

   assign io_out_valid  = out_valid_q;
   assign io_Address    = addr_q;
   assign io_data       = data_q;
   assign io_excp_vaild = excp_q;
   assign io_excp_cause = cause_q;
   assign io_excpt_tval = tval_q;
   assign io_fetch_id   = id_q;

   // Fetch FSM with registered packet outputs; flush overrides everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_VECTOR;
         pkt_pc_q    <= '0;
         misal_q     <= 1'b0;
         out_valid_q <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         excp_q      <= 1'b0;
         cause_q     <= '0;
         tval_q      <= '0;
         id_q        <= '0;
      end else if (io_fetch_flush) begin
         pc_q        <= io_Redirect_Target;
         id_q        <= io_Redirect_ID + 4'd1;
         out_valid_q <= 1'b0;
         misal_q     <= |io_Redirect_Target[1:0];
         state_q     <= outstanding_d ? S_DRAIN : S_REQ;
      end else begin
         case (state_q)
            S_REQ: begin
               if (misal_q) begin
                  // Misaligned target: synthesize the exception packet directly.
                  misal_q     <= 1'b0;
                  addr_q      <= pc_q;
                  data_q      <= '0;
                  excp_q      <= 1'b1;
                  cause_q     <= 6'h0;
                  tval_q      <= pc_q;
                  out_valid_q <= 1'b1;
                  state_q     <= S_HOLD;
               end else if (req_fire) begin
                  pkt_pc_q <= pc_q;
                  pc_q     <= pc_inc_d;
                  state_q  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (io_icache_resp_valid) begin
                  addr_q      <= pkt_pc_q;
                  data_q      <= io_icache_resp_data;
                  excp_q      <= io_icache_resp_excp;
                  cause_q     <= io_icache_resp_cause;
                  tval_q      <= io_icache_resp_excp ? pkt_pc_q : 32'd0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (out_fire) begin
                  id_q        <= id_q + 4'd1;
                  out_valid_q <= 1'b0;
                  state_q     <= excp_q ? S_STOP : S_REQ;
               end
            end
            S_DRAIN: begin
               if (io_icache_resp_valid) state_q <= S_REQ;
            end
            S_STOP: ;
            default: state_q <= S_REQ;
         endcase
      end
   end

`ifdef FETCH_UNIT_PERF_CNT_EN
   logic [31:0] perf_pkts_q, perf_flushes_q;
   assign io_perf_pkts    = perf_pkts_q;
   assign io_perf_flushes = perf_flushes_q;

   // Delivered-packet and flush-cycle counters, free-running with wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_pkts_q    <= '0;
         perf_flushes_q <= '0;
      end else begin
         if (out_fire)       perf_pkts_q    <= perf_pkts_q + 32'd1;
         if (io_fetch_flush) perf_flushes_q <= perf_flushes_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, back-pressure, redirects,
// misaligned redirect, exception stop, PC wrap, and mid-operation reset.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        resp_valid, resp_excp;
   logic [63:0] resp_data;
   logic [5:0]  resp_cause;
   logic        out_valid, out_ready;
   logic [31:0] address, tval;
   logic [63:0] data;
   logic        excp;
   logic [5:0]  cause;
   logic [3:0]  fetch_id;
   logic        flush;
   logic [3:0]  rid;
   logic [31:0] rtgt;

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clock(clock), .reset(reset),
      .io_icache_req_valid(req_valid), .io_icache_req_ready(req_ready),
      .io_icache_req_addr(req_addr),
      .io_icache_resp_valid(resp_valid), .io_icache_resp_data(resp_data),
      .io_icache_resp_excp(resp_excp), .io_icache_resp_cause(resp_cause),
      .io_out_valid(out_valid), .io_out_ready(out_ready),
      .io_Address(address), .io_data(data), .io_excp_vaild(excp),
      .io_excp_cause(cause), .io_excpt_tval(tval), .io_fetch_id(fetch_id),
      .io_fetch_flush(flush), .io_Redirect_ID(rid), .io_Redirect_Target(rtgt)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   initial begin
      reset = 1; req_ready = 0; resp_valid = 0; resp_data = '0; resp_excp = 0;
      resp_cause = '0; out_ready = 0; flush = 0; rid = '0; rtgt = '0;
      tick(); tick();
      reset = 0;
      // Reset state
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_fetch_id", 64'(fetch_id), 64'd0);
      chk("rst_req_valid", 64'(req_valid), 64'd1);
      chk("rst_req_addr", 64'(req_addr), 64'h8000_0000);
      chk("rst_address", 64'(address), 64'd0);
      chk("rst_data", data, 64'd0);

      // Three sequential packets, zero-wait cache
      req_ready = 1;
      for (int k = 0; k < 3; k++) begin
         chk("seq_req_valid", 64'(req_valid), 64'd1);
         chk("seq_req_addr", 64'(req_addr), 64'h8000_0000 + 64'(8 * k));
         tick();
         chk("seq_wait_noreq", 64'(req_valid), 64'd0);
         resp_valid = 1; resp_data = 64'hA5A5_0000_0000_0000 + 64'(k);
         tick();
         resp_valid = 0;
         chk("seq_out_valid", 64'(out_valid), 64'd1);
         chk("seq_address", 64'(address), 64'h8000_0000 + 64'(8 * k));
         chk("seq_data", data, 64'hA5A5_0000_0000_0000 + 64'(k));
         chk("seq_fetch_id", 64'(fetch_id), 64'(k));
         chk("seq_excp", 64'(excp), 64'd0);
         out_ready = 1;
         tick();
         out_ready = 0;
      end
      chk("seq_id_after", 64'(fetch_id), 64'd3);

      // Back-pressure in HOLD for 5 cycles
      chk("bp_req_addr", 64'(req_addr), 64'h8000_0018);
      tick();
      resp_valid = 1; resp_data = 64'h1122_3344_5566_7788;
      tick();
      resp_valid = 0;
      for (int k = 0; k < 5; k++) begin
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_data", data, 64'h1122_3344_5566_7788);
         chk("bp_address", 64'(address), 64'h8000_0018);
         chk("bp_no_req", 64'(req_valid), 64'd0);
         tick();
      end
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("bp_next_addr", 64'(req_addr), 64'h8000_0020);
      chk("bp_next_id", 64'(fetch_id), 64'd4);

      // Flush while WAIT: late response dropped
      tick();
      flush = 1; rtgt = 32'h1004; rid = 4'd7;
      tick();
      flush = 0;
      chk("fw_drain_noreq", 64'(req_valid), 64'd0);
      resp_valid = 1; resp_data = 64'hDEAD_DEAD_DEAD_DEAD;
      tick();
      resp_valid = 0;
      chk("fw_dropped", 64'(out_valid), 64'd0);
      chk("fw_req_valid", 64'(req_valid), 64'd1);
      chk("fw_req_addr", 64'(req_addr), 64'h1000);
      tick();
      resp_valid = 1; resp_data = 64'h0000_1111_2222_3333;
      tick();
      resp_valid = 0;
      chk("fw_out_valid", 64'(out_valid), 64'd1);
      chk("fw_address", 64'(address), 64'h1004);
      chk("fw_data", data, 64'h0000_1111_2222_3333);
      chk("fw_fetch_id", 64'(fetch_id), 64'd8);
      out_ready = 1;
      tick();
      out_ready = 0;

      // Misaligned redirect: exception packet, then STOP
      req_ready = 0;
      flush = 1; rtgt = 32'h2002; rid = 4'd3;
      tick();
      flush = 0;
      chk("mis_no_req", 64'(req_valid), 64'd0);
      tick();
      chk("mis_out_valid", 64'(out_valid), 64'd1);
      chk("mis_excp", 64'(excp), 64'd1);
      chk("mis_cause", 64'(cause), 64'd0);
      chk("mis_tval", 64'(tval), 64'h2002);
      chk("mis_address", 64'(address), 64'h2002);
      chk("mis_data", data, 64'd0);
      chk("mis_id", 64'(fetch_id), 64'd4);
      out_ready = 1;
      tick();
      out_ready = 0;
      req_ready = 1;
      resp_valid = 1; resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
      resp_valid = 0;
      for (int k = 0; k < 3; k++) begin
         chk("stop_no_req", 64'(req_valid), 64'd0);
         chk("stop_no_out", 64'(out_valid), 64'd0);
         tick();
      end

      // Response exception at 0x3000 -> STOP
      flush = 1; rtgt = 32'h3000; rid = 4'd0;
      tick();
      flush = 0;
      chk("ex_req_valid", 64'(req_valid), 64'd1);
      chk("ex_req_addr", 64'(req_addr), 64'h3000);
      tick();
      resp_valid = 1; resp_excp = 1; resp_cause = 6'h1; resp_data = 64'h55;
      tick();
      resp_valid = 0; resp_excp = 0; resp_cause = 6'h0;
      chk("ex_excp", 64'(excp), 64'd1);
      chk("ex_cause", 64'(cause), 64'd1);
      chk("ex_tval", 64'(tval), 64'h3000);
      chk("ex_id", 64'(fetch_id), 64'd1);
      out_ready = 1;
      tick();
      out_ready = 0;
      tick();
      chk("ex_stop_no_req", 64'(req_valid), 64'd0);

      // PC wrap at top of address space, fetch_id wrap
      flush = 1; rtgt = 32'hFFFF_FFF8; rid = 4'd14;
      tick();
      flush = 0;
      chk("wrap_req_addr", 64'(req_addr), 64'hFFFF_FFF8);
      chk("wrap_id", 64'(fetch_id), 64'd15);
      tick();
      resp_valid = 1; resp_data = 64'h77;
      tick();
      resp_valid = 0;
      chk("wrap_address", 64'(address), 64'hFFFF_FFF8);
      chk("wrap_tval", 64'(tval), 64'd0);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("wrap_id_next", 64'(fetch_id), 64'd0);
      chk("wrap_next_addr", 64'(req_addr), 64'h0);

      // Flush coinciding with a request handshake -> drain
      flush = 1; rtgt = 32'h4000; rid = 4'd2;
      tick();
      flush = 0;
      chk("fh_drain_noreq", 64'(req_valid), 64'd0);
      resp_valid = 1;
      tick();
      resp_valid = 0;
      chk("fh_dropped", 64'(out_valid), 64'd0);
      chk("fh_req_addr", 64'(req_addr), 64'h4000);
      chk("fh_id", 64'(fetch_id), 64'd3);

      // Reset mid-operation
      tick();
      reset = 1;
      tick();
      reset = 0;
      chk("mr_req_addr", 64'(req_addr), 64'h8000_0000);
      chk("mr_req_valid", 64'(req_valid), 64'd1);
      chk("mr_id", 64'(fetch_id), 64'd0);
      chk("mr_out_valid", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
